// File: rtl/lsu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arb_pkg
// Purpose  : Shared types and helpers for the LSU request arbiter: request
//            struct layout and the rotating first-valid pick function.
// Config   : LSU_ARB_FAIR_EN selects round-robin in lsu_req_arbiter; this
//            package is the same for both builds.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_arb_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  // Widest requester vector the pick function handles.
  localparam int PICK_MAX = 8;

  typedef struct packed {
    logic              is_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lsu_req_t;

  // Returns the first index with valid set, searching upward from ptr and
  // wrapping at n-1 back to 0. Returns 0 when nothing is valid.
  function automatic int unsigned rr_pick(input logic [PICK_MAX-1:0] valid,
                                          input int unsigned         ptr,
                                          input int unsigned         n);
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < PICK_MAX; i++) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (!found && valid[idx[2:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rr_picker
// Purpose  : Combinational rotating-priority picker. Finds the first valid
//            requester at or after ptr and produces a one-hot grant gated by
//            enable. With ptr tied to zero it degenerates to fixed priority.
// Config   : behaviour selected by the caller through ptr (LSU_ARB_FAIR_EN
//            is resolved in lsu_req_arbiter).
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rr_picker
  import lsu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  localparam int unsigned NUM_REQ_U = NUM_REQ;

  // Rotate-and-search for the winning index.
  always_comb begin
    winner    = IDX_W'(rr_pick(PICK_MAX'(valid), 32'(ptr), NUM_REQ_U));
    any_valid = |valid;
  end

  // One-hot grant; an invalid winner (nothing valid) yields no grant.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_grant
    assign grant[i] = enable & valid[i] & (winner == IDX_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/lsu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_req_arbiter
// Purpose  : Shares the single LSU request port among NUM_REQ requesters.
//            One winner per cycle is registered into a one-entry output
//            stage; outstanding LSU requests are limited by a credit counter;
//            flush drops the output stage and all credit.
// Config   : LSU_ARB_FAIR_EN defined   -> round-robin arbitration.
//            LSU_ARB_FAIR_EN undefined -> fixed priority, lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_req_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  lsu_req_t [NUM_REQ-1:0]     req_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output lsu_req_t                   lsu_req_o,
  output logic                       lsu_valid_o,
  input  logic                       lsu_ready_i,
  input  logic                       lsu_done_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int SUM_W = CNT_W + 1;

  logic               handshake;
  logic               stage_free;
  logic               credit_ok;
  logic               arb_ok;
  logic               accept;
  logic               done_ok;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr_sel;
  logic [IDX_W-1:0]   winner;
  logic               any_valid;

  // Stage/credit qualification for a new grant this cycle. The request
  // leaving the stage on a handshake already consumes a credit, so it is
  // counted before comparing against the limit.
  always_comb begin
    handshake  = lsu_valid_o & lsu_ready_i;
    stage_free = ~lsu_valid_o | lsu_ready_i;
    credit_ok  = (({1'b0, cnt} + SUM_W'(handshake)) < SUM_W'(MAX_OUTST));
    arb_ok     = rst_ni & stage_free & credit_ok & ~flush_i;
    accept     = |(req_valid_i & req_ready_o);
    done_ok    = lsu_done_i & (cnt != '0);
  end

`ifdef LSU_ARB_FAIR_EN
  logic [IDX_W-1:0] rr_ptr;

  // Round-robin pointer: the slot after the last accepted requester.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign ptr_sel = rr_ptr;
`else
  assign ptr_sel = '0;
`endif

  lsu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid     (req_valid_i),
    .ptr       (ptr_sel),
    .enable    (arb_ok),
    .grant     (req_ready_o),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // One-entry output stage; payload holds while waiting on the LSU.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lsu_valid_o <= 1'b0;
      lsu_req_o   <= '0;
      grant_id_o  <= '0;
    end else if (flush_i) begin
      lsu_valid_o <= 1'b0;
    end else if (accept && any_valid) begin
      lsu_req_o   <= req_i[winner];
      lsu_valid_o <= 1'b1;
      grant_id_o  <= winner;
    end else if (handshake) begin
      lsu_valid_o <= 1'b0;
    end
  end

  // Outstanding-request credit: up on handshake, down on retire.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (handshake && !done_ok) begin
      cnt <= cnt + 1'b1;
    end else if (!handshake && done_ok) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_req_arbiter.md
# lsu_req_arbiter

Round-robin arbiter sharing the single LSU request port among NUM_REQ issue-side requesters. It selects one valid requester per cycle and registers the winning request into a one-entry output stage that drives the LSU bypass buffer's request/valid inputs. It tracks outstanding requests against a credit limit and drops all buffered state on flush.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 14: request address width.
- DATA_W, 16: request data width.
- MAX_OUTST, 4: maximum requests issued to the LSU and not yet retired (1..15).
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  drop output-stage request and all outstanding credit.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_i  in  NUM_REQ x lsu_req_t  per-requester request {is_store, addr[ADDR_W], data[DATA_W]}.
- req_ready_o  out  NUM_REQ  per-requester grant; one-hot or zero.
- lsu_req_o  out  lsu_req_t  registered winning request.
- lsu_valid_o  out  1  lsu_req_o valid.
- lsu_ready_i  in  1  LSU accepts lsu_req_o this cycle.
- lsu_done_i  in  1  LSU retired one request (pop_ld or pop_st), returns one credit.
- grant_id_o  out  $clog2(NUM_REQ)  index of requester held in output stage.

## Operation
- Output stage "free" when !lsu_valid_o or (lsu_valid_o and lsu_ready_i).
- Credit counter cnt, width $clog2(MAX_OUTST+1); increments on LSU handshake (lsu_valid_o & lsu_ready_i), decrements on lsu_done_i; both in one cycle leaves it unchanged. lsu_done_i at cnt==0 is ignored.
- Arbitration allowed when stage free, cnt + (pending handshake ? 1 : 0) < MAX_OUTST, and !flush_i.
- Winner: first valid index at or after rr_ptr, wrapping NUM_REQ-1 -> 0. req_ready_o[winner]=1 only when arbitration allowed; a requester is accepted when req_valid_i & req_ready_o.
- On accept: output stage loads req_i[winner], lsu_valid_o=1, grant_id_o=winner; rr_ptr <= (winner+1) mod NUM_REQ.
- No accept and handshake: lsu_valid_o <= 0. lsu_req_o holds stable while lsu_valid_o & !lsu_ready_i.
- flush_i: lsu_valid_o <= 0, cnt <= 0, no grant that cycle, rr_ptr preserved; late lsu_done_i in flush cycle ignored.

## Timing
- Reset values: lsu_valid_o=0, lsu_req_o=0, grant_id_o=0, rr_ptr=0, cnt=0; req_ready_o=0 while rst_ni=0.
- req_ready_o combinational from req_valid_i, rr_ptr, cnt, lsu_valid_o, lsu_ready_i, flush_i; no dependency on req_i.
- Latency: accept in cycle N -> lsu_valid_o in N+1. Back-to-back throughput one request/cycle while lsu_ready_i=1 and credit available.
- Credit full: at cnt==MAX_OUTST no grants; lsu_done_i in cycle N enables grant in N+1.
- Reset asserted mid-transfer: state cleared at that edge, in-flight request lost.

## Configuration
- LSU_ARB_FAIR_EN defined: round-robin as above.
- Not defined: fixed priority, lowest asserted index wins; rr_ptr removed, grant_id_o still reported.

## Structure
- Package lsu_arb_pkg: lsu_req_t struct (is_store, addr, data) parameterized via package constants ADDR_W/DATA_W defaults, and helper function rr_pick(valid, ptr) returning winner index.
- One sub-module: lsu_rr_picker (combinational priority rotate + one-hot grant); credit counter and output stage in top.

## Test plan
- Reset: rst_ni=0 two cycles, req_valid_i=2'b11 -> req_ready_o=0, lsu_valid_o=0; after release first grant goes to requester 0.
- Round robin: both valid continuously, lsu_ready_i=1, lsu_done_i=1 -> grants alternate 0,1,0,1; lsu_req_o addr 14'h1234 / 14'h0567 alternate one cycle after each grant.
- Backpressure: lsu_ready_i=0 for 3 cycles with request {store, 14'h0567, 16'h8901} held -> lsu_req_o stable, req_ready_o=0, no further accepts.
- Credit limit: MAX_OUTST=4, lsu_done_i=0 -> exactly 4 handshakes then req_ready_o=0; single lsu_done_i pulse -> one further grant next cycle.
- Flush: output stage valid with cnt=3, flush_i=1 -> next cycle lsu_valid_o=0, cnt=0, no grant in flush cycle, rr_ptr unchanged.
- Simultaneous handshake and lsu_done_i at cnt=2 -> cnt stays 2.
